// File: rtl/regfile_write_sequencer.sv
// regfile_write_sequencer
//   Write-port sequencer for the ACC/ACCO/SP/RA register file. ALU results and
//   memory-load results are collected into a small in-order FIFO. At most one
//   register-file write is issued per cycle, through a registered output stage.
//
// Optional feature: define WB_BYPASS_EN to add a combinational forwarding
// lookup over the output register and all queued entries.
//
// Ports
//   CLK                     system clock, rising edge
//   rst                     asynchronous reset, active-low
//   stall                   1 = register file must not be written this cycle
//   aluValid/aluAddr/aluData ALU write request
//   aluReady                ALU request accepted on this edge if aluValid
//   memValid/memAddr/memData memory-load write request
//   memReady                load request accepted on this edge if memValid
//   write/wrAddr/wrData     registered write strobe, address and data
//   count                   entries queued (output register not included)
//   empty                   nothing queued and no write in flight
//   lkAddr/fwdHit/fwdData   forwarding lookup (WB_BYPASS_EN only)
module regfile_write_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       CLK,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       aluValid,
  input  logic [ADDR_W-1:0]          aluAddr,
  input  logic [DATA_W-1:0]          aluData,
  output logic                       aluReady,
  input  logic                       memValid,
  input  logic [ADDR_W-1:0]          memAddr,
  input  logic [DATA_W-1:0]          memData,
  output logic                       memReady,
  output logic                       write,
  output logic [ADDR_W-1:0]          wrAddr,
  output logic [DATA_W-1:0]          wrData,
`ifdef WB_BYPASS_EN
  input  logic [ADDR_W-1:0]          lkAddr,
  output logic                       fwdHit,
  output logic [DATA_W-1:0]          fwdData,
`endif
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StDrain, StHold} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   mem_slot;
  logic              write_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              push_alu, push_mem, pop;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  // Readiness looks only at the registered count; a same-cycle pop does not
  // free a slot early.
  always_comb begin
    aluReady = count_q < CntW'(DEPTH);
    memReady = aluValid ? (count_q < CntW'(DEPTH - 1)) : (count_q < CntW'(DEPTH));
    push_alu = aluValid & aluReady;
    push_mem = memValid & memReady;
    pop      = (state_q != StIdle) && !stall && (count_q != '0);
    count_d  = count_q + CntW'(push_alu) + CntW'(push_mem) - CntW'(pop);
    // ALU entry is the older one when both arrive together.
    mem_slot = wr_ptr_q + PtrW'(push_alu);
    wr_ptr_d = wr_ptr_q + PtrW'(push_alu) + PtrW'(push_mem);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (push_alu || push_mem) state_d = StDrain;
      StDrain: begin
        if (count_d == '0)  state_d = StIdle;
        else if (stall)     state_d = StHold;
      end
      StHold:  if (!stall) state_d = (count_d == '0) ? StIdle : StDrain;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      write_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      write_q  <= pop;
      if (pop) begin
        wr_addr_q <= addr_mem[rd_ptr_q];
        wr_data_q <= data_mem[rd_ptr_q];
      end
    end
  end

  // Storage needs no reset: validity is tracked by the pointers and count.
  always_ff @(posedge CLK) begin
    if (push_alu) begin
      addr_mem[wr_ptr_q] <= aluAddr;
      data_mem[wr_ptr_q] <= aluData;
    end
    if (push_mem) begin
      addr_mem[mem_slot] <= memAddr;
      data_mem[mem_slot] <= memData;
    end
  end

  assign write  = write_q;
  assign wrAddr = wr_addr_q;
  assign wrData = wr_data_q;
  assign count  = count_q;
  assign empty  = (count_q == '0) && !write_q;

`ifdef WB_BYPASS_EN
  logic [PtrW-1:0] lk_idx;

  // Scan oldest to youngest so the last match wins; the output register is
  // always older than anything still queued.
  always_comb begin
    fwdHit  = 1'b0;
    fwdData = '0;
    lk_idx  = '0;
    if (write_q && (wr_addr_q == lkAddr)) begin
      fwdHit  = 1'b1;
      fwdData = wr_data_q;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      lk_idx = rd_ptr_q + PtrW'(i);
      if ((CntW'(i) < count_q) && (addr_mem[lk_idx] == lkAddr)) begin
        fwdHit  = 1'b1;
        fwdData = data_mem[lk_idx];
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_sequencer.sv
module tb_regfile_write_sequencer;

  localparam int unsigned DEPTH = 4;

  logic        CLK = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        aluValid = 1'b0;
  logic [1:0]  aluAddr = '0;
  logic [15:0] aluData = '0;
  logic        aluReady;
  logic        memValid = 1'b0;
  logic [1:0]  memAddr = '0;
  logic [15:0] memData = '0;
  logic        memReady;
  logic        write;
  logic [1:0]  wrAddr;
  logic [15:0] wrData;
  logic [2:0]  count;
  logic        empty;
`ifdef WB_BYPASS_EN
  logic [1:0]  lkAddr = '0;
  logic        fwdHit;
  logic [15:0] fwdData;
`endif

  regfile_write_sequencer #(.DATA_W(16), .ADDR_W(2), .DEPTH(DEPTH)) dut (
    .CLK      (CLK),
    .rst      (rst),
    .stall    (stall),
    .aluValid (aluValid),
    .aluAddr  (aluAddr),
    .aluData  (aluData),
    .aluReady (aluReady),
    .memValid (memValid),
    .memAddr  (memAddr),
    .memData  (memData),
    .memReady (memReady),
    .write    (write),
    .wrAddr   (wrAddr),
    .wrData   (wrData),
`ifdef WB_BYPASS_EN
    .lkAddr   (lkAddr),
    .fwdHit   (fwdHit),
    .fwdData  (fwdData),
`endif
    .count    (count),
    .empty    (empty)
  );

  always #5 CLK = ~CLK;

  // Reference model: an ordered list of pending writes plus the write in flight.
  typedef struct packed {
    logic [1:0]  a;
    logic [15:0] d;
  } ent_t;

  ent_t        q[$];
  logic        m_write = 1'b0;
  logic [1:0]  m_addr  = '0;
  logic [15:0] m_data  = '0;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check combinational outputs before the edge,
  // advance the model across the edge, then check registered outputs.
  task automatic tick(input bit st, input bit av, input logic [1:0] aa, input logic [15:0] ad,
                      input bit mv, input logic [1:0] ma, input logic [15:0] md);
    int   n;
    bit   ar, mr, hit;
    logic [15:0] fd;
    ent_t e;
    stall = st; aluValid = av; aluAddr = aa; aluData = ad;
    memValid = mv; memAddr = ma; memData = md;
    #1;
    n  = q.size();
    ar = n < DEPTH;
    mr = av ? (n < DEPTH - 1) : (n < DEPTH);
    check("aluReady", 32'(aluReady), 32'(ar));
    check("memReady", 32'(memReady), 32'(mr));
`ifdef WB_BYPASS_EN
    hit = 1'b0; fd = '0;
    if (m_write && m_addr == lkAddr) begin hit = 1'b1; fd = m_data; end
    foreach (q[i]) if (q[i].a == lkAddr) begin hit = 1'b1; fd = q[i].d; end
    check("fwdHit", 32'(fwdHit), 32'(hit));
    check("fwdData", 32'(fwdData), 32'(fd));
`else
    hit = 1'b0; fd = '0;
`endif
    @(posedge CLK);
    if (n > 0 && !st) begin
      e = q.pop_front();
      m_write = 1'b1; m_addr = e.a; m_data = e.d;
    end else begin
      m_write = 1'b0;
    end
    if (av && ar) q.push_back('{a: aa, d: ad});
    if (mv && mr) q.push_back('{a: ma, d: md});
    #1;
    check("write", 32'(write), 32'(m_write));
    check("wrAddr", 32'(wrAddr), 32'(m_addr));
    check("wrData", 32'(wrData), 32'(m_data));
    check("count", 32'(count), 32'(q.size()));
    check("empty", 32'(empty), 32'(q.size() == 0 && !m_write));
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) tick(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_write", 32'(write), 32'(0));
    check("rst_count", 32'(count), 32'(0));
    check("rst_empty", 32'(empty), 32'(1));
    check("rst_wrData", 32'(wrData), 32'(0));
    @(posedge CLK); #3; rst = 1'b1;
    @(posedge CLK); #1;

    // Single ALU write: accepted, popped next edge, visible one cycle
    tick(0, 1, 2'd0, 16'hD221, 0, 0, 0);
    check("t2_not_yet", 32'(write), 32'(0));
    idle(1);
    check("t2_write", 32'(write), 32'(1));
    check("t2_wrAddr", 32'(wrAddr), 32'(0));
    check("t2_wrData", 32'(wrData), 32'(16'hD221));
    idle(1);
    check("t2_done", 32'(write), 32'(0));
    check("t2_empty", 32'(empty), 32'(1));

    // Same-edge ALU + mem: ALU first
    tick(0, 1, 2'd1, 16'h000F, 1, 2'd2, 16'h1C71);
    idle(1);
    check("t3_first_addr", 32'(wrAddr), 32'(1));
    check("t3_first_data", 32'(wrData), 32'(16'h000F));
    idle(1);
    check("t3_second_addr", 32'(wrAddr), 32'(2));
    check("t3_second_data", 32'(wrData), 32'(16'h1C71));
    idle(2);

    // Fill under stall, both readies drop at full, then drain in order
    for (int i = 0; i < 4; i++) tick(1, 1, 2'(i), 16'hA000 + 16'(i), 0, 0, 0);
    check("t4_full", 32'(count), 32'(4));
    tick(1, 1, 2'd3, 16'hBEEF, 1, 2'd2, 16'hCAFE);
    check("t4_no_write", 32'(write), 32'(0));
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, 0, 0, 0, 0);
      check("t4_order", 32'(wrData), 32'(16'hA000 + 16'(i)));
    end
    idle(2);
    check("t4_idle", 32'(empty), 32'(1));

    // One free slot: ALU wins, mem accepted on the following edge
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 1, 2'(i), 16'h5000 + 16'(i));
    tick(1, 1, 2'd3, 16'h7777, 1, 2'd1, 16'h8888);
    check("t5_alu_in", 32'(count), 32'(4));
    idle(1);
    tick(0, 0, 0, 0, 1, 2'd1, 16'h8888);
    check("t5_mem_in", 32'(count), 32'(3));
    idle(6);

`ifdef WB_BYPASS_EN
    tick(1, 1, 2'd3, 16'hFF00, 0, 0, 0);
    tick(1, 1, 2'd3, 16'h00FF, 0, 0, 0);
    lkAddr = 2'd3; #1;
    check("t6_hit", 32'(fwdHit), 32'(1));
    check("t6_data", 32'(fwdData), 32'(16'h00FF));
    lkAddr = 2'd1; #1;
    check("t6_miss", 32'(fwdHit), 32'(0));
    check("t6_miss_data", 32'(fwdData), 32'(0));
    idle(4);
`endif

    // Async reset mid-drain with three entries queued
    for (int i = 0; i < 4; i++) tick(1, 1, 2'(i), 16'h1100 + 16'(i), 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    check("t1_count3", 32'(count), 32'(3));
    #2; rst = 1'b0; #1;
    check("t1_write", 32'(write), 32'(0));
    check("t1_count", 32'(count), 32'(0));
    check("t1_empty", 32'(empty), 32'(1));
    q.delete(); m_write = 1'b0; m_addr = '0; m_data = '0;
    @(posedge CLK); #3; rst = 1'b1;
    @(posedge CLK); #1;
    idle(3);
    check("t1_quiet", 32'(write), 32'(0));

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
`ifdef WB_BYPASS_EN
      lkAddr = 2'($urandom_range(0, 3));
`endif
      tick($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           16'($urandom), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom));
    end
    idle(DEPTH + 3);
    check("final_empty", 32'(empty), 32'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
